// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects the writeback source, aligns loads across a
// variable-latency memory response, flags faults and counts retired instructions.
module wb_commit_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid_i,
  output logic             wb_ready_o,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_load_regfile_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [WIDTH-1:0] wb_alu_out_i,
  input  logic             wb_br_en_i,
  input  logic [WIDTH-1:0] wb_u_imm_i,
  input  logic [WIDTH-1:0] wb_pc_i,
  input  logic             dmem_resp_i,
  input  logic [WIDTH-1:0] dmem_rdata_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_rd_o,
  output logic [WIDTH-1:0] rf_wdata_o,
  output logic             misalign_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retire_count_o
);

  localparam int unsigned OFF = $clog2(WIDTH / 8);

  localparam logic [3:0] SEL_ALU = 4'd0;
  localparam logic [3:0] SEL_BR  = 4'd1;
  localparam logic [3:0] SEL_UIM = 4'd2;
  localparam logic [3:0] SEL_LW  = 4'd3;
  localparam logic [3:0] SEL_PC4 = 4'd4;
  localparam logic [3:0] SEL_LB  = 4'd5;
  localparam logic [3:0] SEL_LBU = 4'd6;
  localparam logic [3:0] SEL_LH  = 4'd7;
  localparam logic [3:0] SEL_LHU = 4'd8;
  localparam logic [3:0] SEL_LD  = 4'd9;
  localparam logic [3:0] SEL_LWU = 4'd10;

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e           state_q, state_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ld_we_q, ld_we_d;
  logic [3:0]       ld_sel_q, ld_sel_d;
  logic [OFF-1:0]   ld_off_q, ld_off_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic             misalign_q, misalign_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_load, is_illegal, mis;
  logic [WIDTH-1:0] shifted, load_data, nonload_data;
  logic [2:0]       off3;

  // Source decode, load alignment and commit/next-state logic
  always_comb begin
    state_d      = state_q;
    ld_rd_d      = ld_rd_q;
    ld_we_d      = ld_we_q;
    ld_sel_d     = ld_sel_q;
    ld_off_d     = ld_off_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    misalign_d   = 1'b0;
    illegal_d    = 1'b0;
    cnt_d        = cnt_q;
    wb_ready_o   = (state_q == IDLE);

    is_load    = (wb_sel_i == SEL_LW) || ((wb_sel_i >= SEL_LB) && (wb_sel_i <= SEL_LWU));
    is_illegal = (wb_sel_i > SEL_LWU) ||
                 ((WIDTH == 32) && ((wb_sel_i == SEL_LD) || (wb_sel_i == SEL_LWU)));

    case (wb_sel_i)
      SEL_BR:  nonload_data = WIDTH'(wb_br_en_i);
      SEL_UIM: nonload_data = wb_u_imm_i;
      SEL_PC4: nonload_data = wb_pc_i + WIDTH'(4);
      default: nonload_data = wb_alu_out_i;
    endcase

    // The full byte offset doubles as the lane shift; misaligned cases are never written
    shifted = dmem_rdata_i >> {ld_off_q, 3'b000};
    off3    = 3'(ld_off_q);
    case (ld_sel_q)
      SEL_LW:  load_data = WIDTH'($signed(shifted[31:0]));
      SEL_LB:  load_data = WIDTH'($signed(shifted[7:0]));
      SEL_LBU: load_data = WIDTH'(shifted[7:0]);
      SEL_LH:  load_data = WIDTH'($signed(shifted[15:0]));
      SEL_LHU: load_data = WIDTH'(shifted[15:0]);
      SEL_LWU: load_data = WIDTH'(shifted[31:0]);
      default: load_data = shifted;
    endcase
    case (ld_sel_q)
      SEL_LH, SEL_LHU: mis = off3[0];
      SEL_LW, SEL_LWU: mis = (off3[1:0] != 2'b00);
      SEL_LD:          mis = (off3 != 3'b000);
      default:         mis = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (wb_valid_i) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
            rf_rd_d   = wb_rd_i;
            cnt_d     = cnt_q + CNT_W'(1);
          end else if (is_load) begin
            ld_rd_d  = wb_rd_i;
            ld_we_d  = wb_load_regfile_i;
            ld_sel_d = wb_sel_i;
            ld_off_d = wb_alu_out_i[OFF-1:0];
            state_d  = WAIT_LOAD;
          end else begin
            rf_we_d    = wb_load_regfile_i && (wb_rd_i != 5'd0);
            rf_rd_d    = wb_rd_i;
            rf_wdata_d = nonload_data;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_resp_i) begin
          rf_we_d    = ld_we_q && (ld_rd_q != 5'd0) && !mis;
          rf_rd_d    = ld_rd_q;
          if (!mis) rf_wdata_d = load_data;
          misalign_d = mis;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_sel_q   <= '0;
      ld_off_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_sel_q   <= ld_sel_d;
      ld_off_q   <= ld_off_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_rd_o        = rf_rd_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign misalign_o     = misalign_q;
  assign illegal_o      = illegal_q;
  assign retire_count_o = cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: a 32-bit instance with a 4-bit counter and
// a 64-bit instance share stimulus; each has its own valid.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb;
  logic [4:0]  rd;
  logic        lr;
  logic [3:0]  sel;
  logic [63:0] alu, uimm, pc, rdata;
  logic        br, resp;

  logic        ready_a, we_a, mis_a, ill_a;
  logic [4:0]  rd_a;
  logic [31:0] wdata_a;
  logic [3:0]  cnt_out_a;
  logic        ready_b, we_b, mis_b, ill_b;
  logic [4:0]  rd_b;
  logic [63:0] wdata_b;
  logic [31:0] cnt_out_b;

  int total = 0;
  int bad   = 0;
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  always #5 clk = ~clk;

  wb_commit_unit #(.WIDTH(32), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .wb_valid_i(va), .wb_ready_o(ready_a), .wb_rd_i(rd),
    .wb_load_regfile_i(lr), .wb_sel_i(sel), .wb_alu_out_i(alu[31:0]), .wb_br_en_i(br),
    .wb_u_imm_i(uimm[31:0]), .wb_pc_i(pc[31:0]), .dmem_resp_i(resp),
    .dmem_rdata_i(rdata[31:0]), .rf_we_o(we_a), .rf_rd_o(rd_a), .rf_wdata_o(wdata_a),
    .misalign_o(mis_a), .illegal_o(ill_a), .retire_count_o(cnt_out_a));

  wb_commit_unit #(.WIDTH(64), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .wb_valid_i(vb), .wb_ready_o(ready_b), .wb_rd_i(rd),
    .wb_load_regfile_i(lr), .wb_sel_i(sel), .wb_alu_out_i(alu), .wb_br_en_i(br),
    .wb_u_imm_i(uimm), .wb_pc_i(pc), .dmem_resp_i(resp),
    .dmem_rdata_i(rdata), .rf_we_o(we_b), .rf_rd_o(rd_b), .rf_wdata_o(wdata_b),
    .misalign_o(mis_b), .illegal_o(ill_b), .retire_count_o(cnt_out_b));

  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        lr;
    logic [31:0] alu;
    logic        br;
    logic [31:0] uimm;
    logic [31:0] pc;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one load on the selected instance, respond after 'delay' cycles, check commit
  task automatic do_load(input bit use_b, input logic [3:0] sel_v, input logic [4:0] rd_v,
                         input logic [63:0] addr, input logic [63:0] rdata_v, input int delay,
                         input logic exp_we, input logic [63:0] exp_data, input logic exp_mis);
    sel = sel_v; rd = rd_v; lr = 1'b1; alu = addr;
    if (use_b) vb = 1'b1; else va = 1'b1;
    @(posedge clk); @(negedge clk);
    va = 1'b0; vb = 1'b0;
    for (int k = 0; k < delay; k++) begin
      chk("ld_ready_low", use_b ? ready_b : ready_a, 1'b0);
      chk("ld_we_wait", use_b ? we_b : we_a, 1'b0);
      if (k == delay - 1) begin resp = 1'b1; rdata = rdata_v; end
      @(posedge clk); @(negedge clk);
    end
    resp = 1'b0; rdata = '0;
    if (use_b) cnt_b = cnt_b + 32'd1; else cnt_a = cnt_a + 4'd1;
    chk("ld_we", use_b ? we_b : we_a, exp_we);
    if (exp_we) begin
      chk("ld_data", use_b ? wdata_b : 64'(wdata_a), exp_data);
      chk("ld_rd", use_b ? rd_b : rd_a, rd_v);
    end
    chk("ld_mis", use_b ? mis_b : mis_a, exp_mis);
    chk("ld_ready_back", use_b ? ready_b : ready_a, 1'b1);
    chk("ld_cnt", use_b ? cnt_out_b : 64'(cnt_out_a), use_b ? cnt_b : 64'(cnt_a));
  endtask

  initial begin
    //          sel    rd     lr    alu            br    uimm           pc             we    data           ill
    vecs[0] = '{4'd0,  5'd5,  1'b1, 32'h0000_1234, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_1234, 1'b0};
    vecs[1] = '{4'd1,  5'd6,  1'b1, 32'h0,         1'b1, 32'h0,         32'h0,         1'b1, 32'h0000_0001, 1'b0};
    vecs[2] = '{4'd2,  5'd7,  1'b1, 32'h0,         1'b0, 32'hABCD_E000, 32'h0,         1'b1, 32'hABCD_E000, 1'b0};
    vecs[3] = '{4'd4,  5'd8,  1'b1, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{4'd0,  5'd0,  1'b1, 32'h0000_0055, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0};
    vecs[5] = '{4'd12, 5'd9,  1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1};
    vecs[6] = '{4'd0,  5'd10, 1'b0, 32'h0000_0077, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b0};
    vecs[7] = '{4'd9,  5'd3,  1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1};
    vecs[8] = '{4'd15, 5'd4,  1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1};

    rst = 1'b1; va = 1'b0; vb = 1'b0; rd = '0; lr = 1'b0; sel = '0;
    alu = '0; uimm = '0; pc = '0; rdata = '0; br = 1'b0; resp = 1'b0;
    cnt_a = '0; cnt_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_we_a", we_a, 1'b0);
    chk("rst_rd_a", rd_a, 5'd0);
    chk("rst_wdata_a", wdata_a, 32'd0);
    chk("rst_mis_a", mis_a, 1'b0);
    chk("rst_ill_a", ill_a, 1'b0);
    chk("rst_cnt_a", cnt_out_a, 4'd0);
    chk("rst_ready_a", ready_a, 1'b1);
    chk("rst_we_b", we_b, 1'b0);
    chk("rst_cnt_b", cnt_out_b, 32'd0);
    chk("rst_ready_b", ready_b, 1'b1);

    // Back-to-back single-cycle commits on the 32-bit instance
    for (int i = 0; i < 9; i++) begin
      sel = vecs[i].sel; rd = vecs[i].rd; lr = vecs[i].lr; alu = 64'(vecs[i].alu);
      br = vecs[i].br; uimm = 64'(vecs[i].uimm); pc = 64'(vecs[i].pc); va = 1'b1;
      @(posedge clk); @(negedge clk);
      cnt_a = cnt_a + 4'd1;
      chk($sformatf("vec%0d_we", i), we_a, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_data", i), wdata_a, vecs[i].exp_data);
        chk($sformatf("vec%0d_rd", i), rd_a, vecs[i].rd);
      end
      chk($sformatf("vec%0d_ill", i), ill_a, vecs[i].exp_ill);
      chk($sformatf("vec%0d_mis", i), mis_a, 1'b0);
      chk($sformatf("vec%0d_ready", i), ready_a, 1'b1);
      chk($sformatf("vec%0d_cnt", i), cnt_out_a, cnt_a);
    end
    va = 1'b0; br = 1'b0; uimm = '0; pc = '0;
    @(posedge clk); @(negedge clk);
    chk("idle_we", we_a, 1'b0);
    chk("idle_ill", ill_a, 1'b0);

    // Response while idle is ignored
    resp = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); @(negedge clk);
    resp = 1'b0; rdata = '0;
    chk("idle_resp_we", we_a, 1'b0);
    chk("idle_resp_cnt", cnt_out_a, cnt_a);
    chk("idle_resp_ready", ready_a, 1'b1);

    // 32-bit loads
    do_load(1'b0, 4'd5, 5'd11, 64'h1003, 64'h80FF_FFFF, 3, 1'b1, 64'hFFFF_FF80, 1'b0);
    do_load(1'b0, 4'd8, 5'd12, 64'h2002, 64'hBEEF_0000, 1, 1'b1, 64'h0000_BEEF, 1'b0);
    do_load(1'b0, 4'd7, 5'd13, 64'h2001, 64'hBEEF_0000, 2, 1'b0, 64'h0,         1'b1);
    do_load(1'b0, 4'd6, 5'd14, 64'h0001, 64'h0000_9A00, 1, 1'b1, 64'h0000_009A, 1'b0);
    do_load(1'b0, 4'd3, 5'd15, 64'h0000, 64'h8000_0001, 2, 1'b1, 64'h8000_0001, 1'b0);
    do_load(1'b0, 4'd3, 5'd16, 64'h0002, 64'h8000_0001, 1, 1'b0, 64'h0,         1'b1);
    do_load(1'b0, 4'd5, 5'd0,  64'h0000, 64'h0000_0011, 1, 1'b0, 64'h0,         1'b0);

    // 64-bit loads
    do_load(1'b1, 4'd9,  5'd1, 64'h0, 64'h8000_0000_0000_0001, 1, 1'b1, 64'h8000_0000_0000_0001, 1'b0);
    do_load(1'b1, 4'd3,  5'd2, 64'h4, 64'h8765_4321_0000_0000, 2, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0);
    do_load(1'b1, 4'd10, 5'd3, 64'h4, 64'h8765_4321_0000_0000, 1, 1'b1, 64'h0000_0000_8765_4321, 1'b0);
    do_load(1'b1, 4'd9,  5'd4, 64'h4, 64'h8765_4321_0000_0000, 1, 1'b0, 64'h0,                   1'b1);
    do_load(1'b1, 4'd7,  5'd5, 64'h6, 64'h8001_0000_0000_0000, 1, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    do_load(1'b1, 4'd6,  5'd6, 64'h7, 64'hAB00_0000_0000_0000, 3, 1'b1, 64'h0000_0000_0000_00AB, 1'b0);

    // Reset during WAIT_LOAD with a simultaneous response
    sel = 4'd5; rd = 5'd20; lr = 1'b1; alu = 64'h0; va = 1'b1;
    @(posedge clk); @(negedge clk);
    va = 1'b0;
    chk("rstw_ready_low", ready_a, 1'b0);
    rst = 1'b1; resp = 1'b1; rdata = 64'h55;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; resp = 1'b0; rdata = '0;
    cnt_a = '0; cnt_b = '0;
    chk("rstw_we", we_a, 1'b0);
    chk("rstw_rd", rd_a, 5'd0);
    chk("rstw_wdata", wdata_a, 32'd0);
    chk("rstw_cnt_a", cnt_out_a, 4'd0);
    chk("rstw_cnt_b", cnt_out_b, 32'd0);
    chk("rstw_ready", ready_a, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("rstw_we_after", we_a, 1'b0);

    // Counter wrap on the 4-bit instance
    sel = 4'd0; rd = 5'd1; lr = 1'b1; alu = 64'h1; va = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); @(negedge clk);
      cnt_a = cnt_a + 4'd1;
      chk($sformatf("wrap_cnt%0d", i), cnt_out_a, cnt_a);
    end
    va = 1'b0;
    chk("wrap_zero", cnt_out_a, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
